cordic_rotator: RTL and testbench

- Iterative 8-bit CORDIC rotation-mode core that computes cos/sin of an input angle.
- Folds the input into the convergent range (±90°) and runs ITER shift-add iterations on a single datapath.
- Emits pre-negation signed results plus a `neg` flag. It sits directly upstream of the two's-complement converter stage, which consumes each result with `neg` as its flag input.

---
 rtl/cordic_rotator_if.sv | 23 ++
 rtl/cordic_rotator.sv | 143 ++++++++++++++
 tb/tb_cordic_rotator.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cordic_rotator_if.sv
// rtl/cordic_rotator_if.sv - angle request / cos-sin result handshake bundle for cordic_rotator
interface cordic_rotator_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] angle_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] cos_out;
  logic [7:0] sin_out;
  logic       neg;

  // Upstream/downstream side: presents angles, consumes results
  modport master (
    output in_valid, angle_in, out_ready,
    input  in_ready, out_valid, cos_out, sin_out, neg
  );

  // Core side
  modport slave (
    input  in_valid, angle_in, out_ready,
    output in_ready, out_valid, cos_out, sin_out, neg
  );
endinterface

// File: rtl/cordic_rotator.sv
// rtl/cordic_rotator.sv - iterative 8-bit CORDIC rotation core producing pre-negation cos/sin
module cordic_rotator #(
  parameter int ITER = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  cordic_rotator_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_DONE} state_t;

  localparam logic [2:0]        LAST   = 3'(ITER - 1);
  localparam logic signed [9:0] X_INIT = 10'sd155;

  state_t state_q, state_d;

  logic signed [9:0]  x_q, y_q, x_nx, y_nx;
  logic signed [11:0] z_q, z_nx;
  logic [2:0]         cnt_q;
  logic               neg_z_q;
  logic [7:0]         cos_q, sin_q;
  logic               neg_q;

  logic               accept, step, last;
  logic signed [7:0]  a;
  logic signed [11:0] a_ext, z_init;
  logic               fold;

  // atan(2^-i) with 4096 units per full turn
  function automatic logic signed [11:0] atan_lut(input logic [2:0] i);
    case (i)
      3'd0:    atan_lut = 12'sd512;
      3'd1:    atan_lut = 12'sd302;
      3'd2:    atan_lut = 12'sd160;
      3'd3:    atan_lut = 12'sd81;
      3'd4:    atan_lut = 12'sd41;
      3'd5:    atan_lut = 12'sd20;
      3'd6:    atan_lut = 12'sd10;
      default: atan_lut = 12'sd5;
    endcase
  endfunction

  assign a    = bus.angle_in;
  assign last = (cnt_q == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    accept        = 1'b0;
    step          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        step = 1'b1;
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Fold the angle into +-90 deg; a 180 deg fold is undone downstream via neg
  always_comb begin
    a_ext  = {{4{a[7]}}, a};
    z_init = a_ext <<< 4;
    fold   = 1'b0;
    if (a >= 8'sd64) begin
      z_init = (a_ext - 12'sd128) <<< 4;
      fold   = 1'b1;
    end else if (a < -8'sd64) begin
      z_init = (a_ext + 12'sd128) <<< 4;
      fold   = 1'b1;
    end
  end

  // One shift-add micro-rotation, direction chosen by the sign of residual angle
  always_comb begin
    x_nx = x_q;
    y_nx = y_q;
    z_nx = z_q;
    if (!z_q[11]) begin
      x_nx = x_q - (y_q >>> cnt_q);
      y_nx = y_q + (x_q >>> cnt_q);
      z_nx = z_q - atan_lut(cnt_q);
    end else begin
      x_nx = x_q + (y_q >>> cnt_q);
      y_nx = y_q - (x_q >>> cnt_q);
      z_nx = z_q + atan_lut(cnt_q);
    end
  end

  // Datapath: load on accept, iterate, and round Q1.8 down to Q1.6 on the last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      neg_z_q <= 1'b0;
      cos_q   <= '0;
      sin_q   <= '0;
      neg_q   <= 1'b0;
    end else if (accept) begin
      x_q     <= X_INIT;
      y_q     <= '0;
      z_q     <= z_init;
      cnt_q   <= '0;
      neg_z_q <= fold;
    end else if (step) begin
      x_q   <= x_nx;
      y_q   <= y_nx;
      z_q   <= z_nx;
      cnt_q <= last ? 3'd0 : cnt_q + 3'd1;
      if (last) begin
        cos_q <= 8'((x_nx + 10'sd2) >>> 2);
        sin_q <= 8'((y_nx + 10'sd2) >>> 2);
        neg_q <= neg_z_q;
      end
    end
  end

  assign bus.cos_out = cos_q;
  assign bus.sin_out = sin_q;
  assign bus.neg     = neg_q;

endmodule

// File: tb/tb_cordic_rotator.sv
// tb/tb_cordic_rotator.sv - directed self-checking bench for cordic_rotator
module tb_cordic_rotator;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  cordic_rotator_if bus();

  cordic_rotator #(.ITER(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int c, input int s, input int n);
    check({tag, "_cos"}, int'($signed(bus.cos_out)), c);
    check({tag, "_sin"}, int'($signed(bus.sin_out)), s);
    check({tag, "_neg"}, int'(bus.neg), n);
  endtask

  task automatic issue(input logic [7:0] ang);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.angle_in = ang;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Called #1 after the accept edge; counts edges from accept (inclusive) to out_valid
  task automatic wait_out(input string tag);
    int n;
    n = 1;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, n, 9);
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_ovld_drop"}, int'(bus.out_valid), 0);
  endtask

  task automatic run(input string tag, input logic [7:0] ang, input int c, input int s, input int n);
    issue(ang);
    check({tag, "_busy"}, int'(bus.in_ready), 0);
    wait_out(tag);
    check_outs(tag, c, s, n);
    handshake(tag);
    check_outs({tag, "_hold"}, c, s, n);
  endtask

  initial begin
    int seen;
    total         = 0;
    bad           = 0;
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.angle_in  = 8'd0;

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check_outs("rst", 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run("a0",     8'd0,    64,   0, 0);
    run("a32",    8'd32,   45,  46, 0);
    run("am128",  8'h80,   64,   0, 1);
    run("a64",    8'd64,    0, -64, 1);
    run("am64",   8'hC0,    0, -64, 0);

    // Backpressure: second angle waits until after the handshake
    issue(8'd0);
    wait_out("bp0");
    bus.in_valid = 1'b1;
    bus.angle_in = 8'd32;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp_in_ready", int'(bus.in_ready), 0);
      check("bp_out_valid", int'(bus.out_valid), 1);
      check_outs("bp_stable", 64, 0, 0);
    end
    handshake("bp0");
    check("bp_idle_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_accepted", int'(bus.in_ready), 0);
    wait_out("bp32");
    check_outs("bp32", 45, 46, 0);
    handshake("bp32");

    // Reset mid-iteration aborts the operation
    issue(8'd64);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready", int'(bus.in_ready), 1);
    check_outs("abort_rst", 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1;
    end
    check("abort_no_valid", seen, 0);

    // Async reset mid-clock clears held, non-zero outputs without an edge
    run("pre_rst", 8'h80, 64, 0, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst2_in_ready", int'(bus.in_ready), 1);
    check("rst2_out_valid", int'(bus.out_valid), 0);
    check_outs("rst2", 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
